// File: rtl/halo_receiver.sv
// rtl/halo_receiver.sv - halo partial-sum receiver: per-neighbor FIFOs, round-robin read-modify-write accumulate
//
// Ports:
//   clk, reset (async, active-high), channel_group_done (clears exchange state)
//   neighbor_input_* : per-neighbor {value,row,column} with write enable; neighbor_exchange_done levels
//   clear_to_send    : neighbors may send (registered, guarantees two free slots per FIFO)
//   exchange_done    : all neighbors done and everything committed (registered, sticky until group done)
//   overflow_error   : sticky, a push found its FIFO full
//   buffer_*_read    : read port of the output buffer, data returns one cycle after the strobe
//   buffer_*_write   : write port carrying the saturated accumulated value
module halo_receiver #(
    parameter int BANK_COUNT = 32,
    parameter int TILE_SIZE  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              channel_group_done,
    input  logic [7:0][7:0]                   neighbor_input_value,
    input  logic [7:0][$clog2(TILE_SIZE)-1:0] neighbor_input_row,
    input  logic [7:0][$clog2(TILE_SIZE)-1:0] neighbor_input_column,
    input  logic [7:0]                        neighbor_input_write_enable,
    input  logic [7:0]                        neighbor_exchange_done,
    output logic                              clear_to_send,
    output logic                              exchange_done,
    output logic                              overflow_error,
    output logic [$clog2(BANK_COUNT)-1:0]     buffer_bank_read,
    output logic [$clog2(TILE_SIZE)-1:0]      buffer_row_read,
    output logic [$clog2(TILE_SIZE)-1:0]      buffer_column_read,
    output logic                              buffer_read_enable,
    input  logic [7:0]                        buffer_data_read,
    output logic [$clog2(BANK_COUNT)-1:0]     buffer_bank_write,
    output logic [$clog2(TILE_SIZE)-1:0]      buffer_row_write,
    output logic [$clog2(TILE_SIZE)-1:0]      buffer_column_write,
    output logic [7:0]                        buffer_data_write,
    output logic                              buffer_write_enable
);
    localparam int NN = 8;
    localparam int RW = $clog2(TILE_SIZE);
    localparam int BW = $clog2(BANK_COUNT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = 8 + 2 * RW;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CTS_LIMIT  = CW'(FIFO_DEPTH - 2);

    // FIFO storage and pointers; entry layout is {value, row, column}
    logic [EW-1:0] fifo_mem_q [NN][FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q [NN];
    logic [PW-1:0] wr_ptr_d [NN];
    logic [PW-1:0] rd_ptr_q [NN];
    logic [PW-1:0] rd_ptr_d [NN];
    logic [CW-1:0] count_q [NN];
    logic [CW-1:0] count_d [NN];
    logic [NN-1:0] push;
    logic [NN-1:0] pop;
    logic          overflow_hit;
    logic          cts_ok;
    logic          all_empty;

    // arbiter
    logic [2:0]    rr_ptr_q;
    logic [2:0]    rr_ptr_d;
    logic [2:0]    cand;
    logic          grant_valid;
    logic [2:0]    grant_idx;
    logic [EW-1:0] head_entry;
    logic [7:0]    r_value;
    logic [RW-1:0] r_row;
    logic [RW-1:0] r_col;

    // write stage
    logic          w_valid_q;
    logic          w_valid_d;
    logic [RW-1:0] w_row_q;
    logic [RW-1:0] w_row_d;
    logic [RW-1:0] w_col_q;
    logic [RW-1:0] w_col_d;
    logic [7:0]    w_value_q;
    logic [7:0]    w_value_d;
    logic          fwd_valid_q;
    logic          fwd_valid_d;
    logic [7:0]    fwd_data_q;
    logic [7:0]    fwd_data_d;
    logic [7:0]    w_base;
    logic [8:0]    w_sum_wide;
    logic [7:0]    w_sum;

    // status
    logic          cts_q;
    logic          cts_d;
    logic          exd_q;
    logic          exd_d;
    logic          ovf_q;
    logic          ovf_d;
    logic [NN-1:0] done_q;
    logic [NN-1:0] done_d;
    logic          exd_cond;

    // Round-robin search starting at the pointer; first non-empty FIFO wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NN; k++) begin
            cand = rr_ptr_q + 3'(k);
            if (!grant_valid && (count_q[cand] != '0)) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign head_entry = fifo_mem_q[grant_idx][rd_ptr_q[grant_idx]];
    assign r_value    = head_entry[EW-1 -: 8];
    assign r_row      = head_entry[2*RW-1 -: RW];
    assign r_col      = head_entry[RW-1:0];
    assign rr_ptr_d   = grant_valid ? (grant_idx + 3'd1) : rr_ptr_q;

    // A full FIFO still accepts a push when it is popped in the same cycle.
    always_comb begin
        push         = '0;
        pop          = '0;
        overflow_hit = 1'b0;
        cts_ok       = 1'b1;
        all_empty    = 1'b1;
        for (int i = 0; i < NN; i++) begin
            pop[i]  = grant_valid && (grant_idx == 3'(i));
            push[i] = neighbor_input_write_enable[i] && ((count_q[i] != FULL_COUNT) || pop[i]);
            if (neighbor_input_write_enable[i] && !push[i]) begin
                overflow_hit = 1'b1;
            end
            wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
            count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
            if (count_d[i] > CTS_LIMIT) begin
                cts_ok = 1'b0;
            end
            if (count_q[i] != '0) begin
                all_empty = 1'b0;
            end
        end
    end

    // The buffer returns pre-write data when R and W hit the same location,
    // so the sum just written is carried into the next W step instead.
    assign w_base     = fwd_valid_q ? fwd_data_q : buffer_data_read;
    assign w_sum_wide = {1'b0, w_base} + {1'b0, w_value_q};
    assign w_sum      = w_sum_wide[8] ? 8'hFF : w_sum_wide[7:0];

    always_comb begin
        w_valid_d   = grant_valid;
        w_row_d     = grant_valid ? r_row : '0;
        w_col_d     = grant_valid ? r_col : '0;
        w_value_d   = grant_valid ? r_value : '0;
        fwd_valid_d = grant_valid && w_valid_q && (r_row == w_row_q) && (r_col == w_col_q);
        fwd_data_d  = w_sum;
    end

    // Exchange completes only once nothing is queued, in flight or arriving.
    assign exd_cond = (&done_q) && all_empty && !w_valid_q && !(|neighbor_input_write_enable);

    always_comb begin
        cts_d  = cts_ok;
        ovf_d  = ovf_q | overflow_hit;
        done_d = channel_group_done ? '0 : (done_q | neighbor_exchange_done);
        exd_d  = channel_group_done ? 1'b0 : (exd_q | exd_cond);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NN; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_ptr_q    <= '0;
            w_valid_q   <= 1'b0;
            w_row_q     <= '0;
            w_col_q     <= '0;
            w_value_q   <= '0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
            cts_q       <= 1'b1;
            exd_q       <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= '0;
        end else begin
            for (int i = 0; i < NN; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            rr_ptr_q    <= rr_ptr_d;
            w_valid_q   <= w_valid_d;
            w_row_q     <= w_row_d;
            w_col_q     <= w_col_d;
            w_value_q   <= w_value_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_data_q  <= fwd_data_d;
            cts_q       <= cts_d;
            exd_q       <= exd_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NN; i++) begin
            if (push[i]) begin
                fifo_mem_q[i][wr_ptr_q[i]] <= {neighbor_input_value[i], neighbor_input_row[i],
                                               neighbor_input_column[i]};
            end
        end
    end

    assign clear_to_send       = cts_q;
    assign exchange_done       = exd_q;
    assign overflow_error      = ovf_q;
    assign buffer_read_enable  = grant_valid;
    assign buffer_row_read     = grant_valid ? r_row : '0;
    assign buffer_column_read  = grant_valid ? r_col : '0;
    assign buffer_bank_read    = grant_valid ? BW'(r_col) : '0;
    assign buffer_write_enable = w_valid_q;
    assign buffer_row_write    = w_row_q;
    assign buffer_column_write = w_col_q;
    assign buffer_bank_write   = BW'(w_col_q);
    assign buffer_data_write   = w_valid_q ? w_sum : 8'h00;
endmodule

// File: tb/tb_halo_receiver.sv
// tb/tb_halo_receiver.sv - self-checking bench for halo_receiver against a queue-based reference model
module tb_halo_receiver;
    localparam int DEPTH = 4;
    localparam int BANKS = 32;

    logic clk = 1'b0;
    logic reset;
    logic cgd;
    logic [7:0][7:0] niv;
    logic [7:0][4:0] nir;
    logic [7:0][4:0] nic;
    logic [7:0] nwe;
    logic [7:0] ned;
    logic cts, exd, ovf;
    logic [4:0] brb, brr, brc, bwb, bwr, bwc;
    logic bre, bwe;
    logic [7:0] bdr = 8'h00;
    logic [7:0] bdw;

    halo_receiver #(.BANK_COUNT(BANKS), .TILE_SIZE(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .channel_group_done(cgd),
        .neighbor_input_value(niv), .neighbor_input_row(nir), .neighbor_input_column(nic),
        .neighbor_input_write_enable(nwe), .neighbor_exchange_done(ned),
        .clear_to_send(cts), .exchange_done(exd), .overflow_error(ovf),
        .buffer_bank_read(brb), .buffer_row_read(brr), .buffer_column_read(brc),
        .buffer_read_enable(bre), .buffer_data_read(bdr),
        .buffer_bank_write(bwb), .buffer_row_write(bwr), .buffer_column_write(bwc),
        .buffer_data_write(bdw), .buffer_write_enable(bwe)
    );

    always #5 clk = ~clk;

    // Output buffer: synchronous read, one-cycle latency, pre-write data on collision.
    logic [7:0] bus_mem [32][32];
    always @(posedge clk) begin
        if (bre) bdr <= bus_mem[brr][brc];
        if (bwe) bus_mem[bwr][bwc] = bdw;
    end

    typedef struct packed {
        logic [7:0] v;
        logic [4:0] r;
        logic [4:0] c;
    } ent_t;

    ent_t       mq [8][$];
    int         m_ptr;
    logic [7:0] m_mem [32][32];
    bit         exp_w_valid;
    logic [4:0] exp_w_r, exp_w_c;
    logic [7:0] exp_w_d;
    bit         m_cts, m_ovf, m_exd;
    logic [7:0] m_done;

    logic [7:0] s_val [8];
    logic [4:0] s_row [8];
    logic [4:0] s_col [8];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_src(input int i, input logic [7:0] v, input logic [4:0] r, input logic [4:0] c);
        s_val[i] = v;
        s_row[i] = r;
        s_col[i] = c;
    endtask

    task automatic preset(input int r, input int c, input logic [7:0] v);
        bus_mem[r][c] = v;
        m_mem[r][c]   = v;
    endtask

    // Called at a negedge: check this cycle's outputs, drive inputs, advance the model, move to next negedge.
    task automatic step(input logic [7:0] we, input logic [7:0] nd, input logic cg);
        int   g;
        int   s;
        ent_t e;
        bit   cond;
        bit   empty;
        g = -1;
        empty = 1;
        for (int k = 0; k < 8; k++) begin
            if (mq[k].size() != 0) empty = 0;
            if (g < 0 && mq[(m_ptr + k) % 8].size() != 0) g = (m_ptr + k) % 8;
        end
        check_eq("rd_en", bre, g >= 0);
        if (g >= 0) begin
            e = mq[g][0];
            check_eq("rd_row", brr, e.r);
            check_eq("rd_col", brc, e.c);
            check_eq("rd_bank", brb, e.c % BANKS);
        end
        check_eq("wr_en", bwe, exp_w_valid);
        if (exp_w_valid) begin
            check_eq("wr_row", bwr, exp_w_r);
            check_eq("wr_col", bwc, exp_w_c);
            check_eq("wr_bank", bwb, exp_w_c % BANKS);
            check_eq("wr_data", bdw, exp_w_d);
        end
        check_eq("cts", cts, m_cts);
        check_eq("overflow", ovf, m_ovf);
        check_eq("exch_done", exd, m_exd);

        nwe = we;
        ned = nd;
        cgd = cg;
        for (int i = 0; i < 8; i++) begin
            niv[i] = s_val[i];
            nir[i] = s_row[i];
            nic[i] = s_col[i];
        end

        cond = (m_done == 8'hFF) && empty && !exp_w_valid && (we == 8'h00);
        if (g >= 0) begin
            e = mq[g].pop_front();
            m_ptr = (g + 1) % 8;
            s = int'(m_mem[e.r][e.c]) + int'(e.v);
            if (s > 255) s = 255;
            m_mem[e.r][e.c] = 8'(s);
            exp_w_valid = 1;
            exp_w_r = e.r;
            exp_w_c = e.c;
            exp_w_d = 8'(s);
        end else begin
            exp_w_valid = 0;
        end
        for (int i = 0; i < 8; i++) begin
            if (we[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back({s_val[i], s_row[i], s_col[i]});
                else m_ovf = 1;
            end
        end
        m_cts = 1;
        for (int i = 0; i < 8; i++) if (DEPTH - mq[i].size() < 2) m_cts = 0;
        m_exd  = cg ? 0 : (m_exd | cond);
        m_done = cg ? 8'h00 : (m_done | nd);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_wr_en_async", bwe, 0);
        check_eq("rst_rd_en_async", bre, 0);
        nwe = '0;
        ned = '0;
        cgd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_cts", cts, 1);
        check_eq("rst_exd", exd, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_addr", {brb, brr, brc, bwb, bwr, bwc}, 0);
        check_eq("rst_wdata", bdw, 0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) mq[i].delete();
        m_ptr = 0;
        exp_w_valid = 0;
        m_cts = 1;
        m_ovf = 0;
        m_exd = 0;
        m_done = 8'h00;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                m_mem[r][c] = bus_mem[r][c];
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        bit         found;
        bit         midop_done;
        logic [7:0] we;
        logic [7:0] nd_lvl;
        logic       cg;

        reset = 1'b1;
        cgd = 1'b0;
        nwe = '0;
        ned = '0;
        niv = '0;
        nir = '0;
        nic = '0;
        for (int i = 0; i < 8; i++) set_src(i, 8'd0, 5'd0, 5'd0);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                bus_mem[r][c] = 8'($urandom_range(255));
        @(negedge clk);
        do_reset();

        // basic read-modify-write: 20 + 10 at (5,7)
        preset(5, 7, 8'd20);
        set_src(3, 8'd10, 5'd5, 5'd7);
        step(8'b0000_1000, 8'h00, 1'b0);
        idle(3);
        check_eq("t1_mem", bus_mem[5][7], 30);

        // two hits on the same location back-to-back need forwarding
        preset(2, 2, 8'd0);
        set_src(0, 8'd1, 5'd2, 5'd2);
        set_src(5, 8'd1, 5'd2, 5'd2);
        step(8'b0010_0001, 8'h00, 1'b0);
        idle(4);
        check_eq("t3_fwd_mem", bus_mem[2][2], 2);

        // saturation
        preset(3, 9, 8'd100);
        set_src(2, 8'd200, 5'd3, 5'd9);
        step(8'b0000_0100, 8'h00, 1'b0);
        idle(3);
        check_eq("t4_sat_mem", bus_mem[3][9], 255);

        // all eight neighbors at once, pointer at 0
        do_reset();
        for (int i = 0; i < 8; i++) set_src(i, 8'($urandom_range(255)), 5'd1, 5'(i));
        step(8'hFF, 8'h00, 1'b0);
        idle(10);

        // FIFO fill on neighbor 1 while neighbors 2..7 hold the arbiter
        do_reset();
        for (int i = 0; i < 8; i++) set_src(i, 8'd3, 5'd4, 5'(i + 8));
        step(8'b0000_0010, 8'h00, 1'b0);
        idle(3);
        step(8'b1111_1110, 8'h00, 1'b0);
        step(8'b0000_0010, 8'h00, 1'b0);
        check_eq("t5_cts_after2", cts, 1);
        step(8'b0000_0010, 8'h00, 1'b0);
        check_eq("t5_cts_after3", cts, 0);
        step(8'b0000_0010, 8'h00, 1'b0);
        check_eq("t5_ovf_after4", ovf, 0);
        step(8'b0000_0010, 8'h00, 1'b0);
        check_eq("t5_ovf_after5", ovf, 1);
        idle(12);

        // exchange_done waits for queued data, then clears on channel_group_done
        do_reset();
        set_src(0, 8'd5, 5'd6, 5'd1);
        set_src(1, 8'd6, 5'd6, 5'd2);
        step(8'b0000_0011, 8'h00, 1'b0);
        found = 0;
        for (int n = 0; n < 12 && !found; n++) begin
            if (exd) found = 1;
            else step(8'h00, 8'hFF, 1'b0);
        end
        check_eq("t6_exd_rise", found, 1);
        step(8'h00, 8'h00, 1'b1);
        check_eq("t6_exd_clear", exd, 0);
        idle(2);

        // randomized traffic with a reset while a write is in flight
        do_reset();
        midop_done = 0;
        nd_lvl = 8'h00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!midop_done && cyc >= 1500 && exp_w_valid) begin
                do_reset();
                midop_done = 1;
                nd_lvl = 8'h00;
            end
            we = '0;
            for (int i = 0; i < 8; i++) begin
                set_src(i, ($urandom_range(1) == 0) ? 8'($urandom_range(15)) : 8'($urandom_range(255)),
                        5'($urandom_range(3)), 5'($urandom_range(3)));
                if ((cts || $urandom_range(49) == 0) && $urandom_range(3) == 0) we[i] = 1'b1;
            end
            if ($urandom_range(29) == 0) nd_lvl[$urandom_range(7)] = 1'b1;
            cg = ($urandom_range(149) == 0);
            step(we, nd_lvl, cg);
            if (cg) nd_lvl = 8'h00;
        end
        idle(20);
        check_eq("midop_reset_seen", midop_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/halo_receiver.md
Name: halo_receiver

Overview:
- Receive end of the PPU neighbor-exchange interface: accepts halo partial sums that the 8 neighbor tiles drive on their neighbor_output_* lines.
- Buffers them per neighbor, arbitrates round-robin and accumulates each value into the local tile's output buffer banks by read-modify-write.
- Drives clear_to_send back to the neighbors and reports exchange_done once all neighbors have finished and every received value has been committed.

Parameters:
BANK_COUNT, 32, number of output buffer banks; bank = column mod BANK_COUNT
TILE_SIZE, 32, tile edge length; row/column width is $clog2(TILE_SIZE)
FIFO_DEPTH, 4, entries per neighbor FIFO (power of two, >=2)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
channel_group_done  input  1  pulse; clears exchange state for the next channel group
neighbor_input_value  input  8 x [8]  halo data per neighbor
neighbor_input_row  input  $clog2(TILE_SIZE) x [8]  target row
neighbor_input_column  input  $clog2(TILE_SIZE) x [8]  target column
neighbor_input_write_enable  input  1 x [8]  valid per neighbor
neighbor_exchange_done  input  1 x [8]  level; neighbor has sent its last value
clear_to_send  output  1  neighbors may send this cycle
exchange_done  output  1  all neighbors done and all data committed
overflow_error  output  1  sticky; a push hit a full FIFO
buffer_bank_read  output  $clog2(BANK_COUNT)  read bank
buffer_row_read  output  $clog2(TILE_SIZE)  read row
buffer_column_read  output  $clog2(TILE_SIZE)  read column
buffer_read_enable  output  1  read strobe
buffer_data_read  input  8  read data, valid 1 cycle after the strobe
buffer_bank_write  output  $clog2(BANK_COUNT)  write bank
buffer_row_write  output  $clog2(TILE_SIZE)  write row
buffer_column_write  output  $clog2(TILE_SIZE)  write column
buffer_data_write  output  8  accumulated value
buffer_write_enable  output  1  write strobe

Behaviour:
- Reset: all FIFOs empty, round-robin pointer=0, done latches=0, overflow_error=0, pipeline empty.
  - Outputs at reset: clear_to_send=1, exchange_done=0, both enables=0, all address/data outputs=0.
- Push: each cycle, every neighbor i with write_enable=1 pushes {value,row,column} into FIFO i. All 8 may push in the same cycle.
  - Push into a full FIFO: entry dropped, overflow_error set until reset. Pop+push in the same cycle on a full FIFO is legal and not an overflow.
- clear_to_send: registered; =1 iff every FIFO has >=2 free entries after this cycle's push/pop. This covers the one-cycle sender reaction delay.
- Arbitration (stage R): one pop per cycle among non-empty FIFOs.
  - Round-robin search starts at the pointer; after a grant the pointer becomes grant+1 mod 8.
  - The granted entry drives buffer_read_enable=1 with bank = column[$clog2(BANK_COUNT)-1:0], plus row/column.
- Stage W, next cycle: sum = buffer_data_read + value, unsigned, saturated at 255.
  - Drives buffer_write_enable=1 with the same bank/row/column. Read-to-write latency 1 cycle; sustained throughput 1 entry/cycle.
- Hazard: if stage R reads the same bank/row/column that stage W writes in that cycle, the following W step uses the W sum (forwarded) instead of buffer_data_read.
- Done latches: done[i] set when neighbor_exchange_done[i]=1; held until channel_group_done or reset.
- exchange_done: registered; =1 iff all 8 done latches set, all FIFOs empty, stage R and W idle, and no write_enable this cycle. Held until channel_group_done.
- channel_group_done: clears done latches and exchange_done next cycle; does not flush FIFOs or the pipeline. Data pushed in the same cycle is kept.
- Reset mid-operation: queued and in-flight entries discarded; write_enable deasserts immediately (asynchronous reset).

Test Plan:
1. Neighbor 3 sends value 10 to (row 5, col 7), buffer(7,5,7)=20 -> cycle+1 read bank 7 row 5 col 7; cycle+2 write 30 to the same location.
2. All 8 neighbors push once in the same cycle to distinct columns 0..7, pointer=0 -> 8 writes on consecutive cycles in order 0..7; clear_to_send stays 1.
3. Neighbors 0 and 5 both send value 1 to (2,2) back-to-back, memory=0 -> second write is 2 via forwarding, not 1.
4. Value 200 into a location holding 100 -> write 255.
5. Neighbor 1 pushes 4 entries while the arbiter is stalled by other neighbors, FIFO_DEPTH=4 -> clear_to_send drops after the 3rd push; a 5th push sets overflow_error.
6. All neighbor_exchange_done asserted with 2 entries still queued -> exchange_done rises only after the last write; channel_group_done pulse -> exchange_done=0 next cycle.
